// File: rtl/comms_pkg.sv
// Shared types and constants for the report packet / UART transmit path.
package comms_pkg;

  localparam int         PKT_LEN       = 4;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} pkt_state_t;
  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first; tx is registered and idles high.
module uart_tx_byte
  import comms_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       byte_done,
  output logic       tx
);

  localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_end;

  assign bit_end    = (cnt == '0);
  assign byte_ready = (state == U_IDLE);
  // Asserted during the last cycle of the stop bit so the next frame can
  // start after exactly one idle cycle.
  assign byte_done  = (state == U_STOP) && bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= U_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        U_IDLE: begin
          if (byte_valid) begin
            state <= U_START;
            cnt   <= CNT_MAX;
            shreg <= byte_data;
            tx    <= 1'b0;
          end
        end
        U_START: begin
          if (bit_end) begin
            state   <= U_DATA;
            cnt     <= CNT_MAX;
            bit_idx <= '0;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        U_DATA: begin
          if (bit_end) begin
            cnt <= CNT_MAX;
            if (bit_idx == 3'd7) begin
              state <= U_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        U_STOP: begin
          if (bit_end) begin
            state <= U_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= U_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/report_uart_tx.sv
// Builds the 4-byte health report (sync, seq, health, checksum) and sends it
// over the UART byte serializer, handshaking with the mission FSM.
module report_uart_tx
  import comms_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic [1:0] health_in,
  output logic       data_ready,
  output logic       transmission_complete,
  output logic       busy,
  output logic [7:0] seq_out,
  output logic       tx
);

  pkt_state_t state;
  logic [1:0] byte_idx;
  logic [7:0] seq;
  logic [1:0] health;
  logic       byte_valid;
  logic       byte_ready;
  logic       byte_done;
  logic [7:0] byte_data;

  function automatic logic [7:0] pkt_checksum(input logic [7:0] s, input logic [1:0] h);
    return SYNC_BYTE + s + {6'b0, h};
  endfunction

  assign data_ready            = (state == IDLE);
  assign busy                  = (state != IDLE);
  assign transmission_complete = (state == DONE);
  assign seq_out               = seq;

  // A byte is launched from the first SEND cycle and from each GAP cycle;
  // byte_ready drops as soon as the serializer takes it.
  assign byte_valid = byte_ready && ((state == SEND) || (state == GAP));

  always_comb begin
    byte_data = SYNC_BYTE;
    case (byte_idx)
      2'd0:    byte_data = SYNC_BYTE;
      2'd1:    byte_data = seq;
      2'd2:    byte_data = {6'b0, health};
      default: byte_data = pkt_checksum(seq, health);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byte_idx <= '0;
      seq      <= '0;
      health   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (data_valid) begin
            state    <= SEND;
            byte_idx <= '0;
            health   <= health_in;
          end
        end
        SEND: begin
          if (byte_done) begin
            if (byte_idx == 2'(PKT_LEN - 1)) begin
              state <= DONE;
            end else begin
              state    <= GAP;
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        GAP:  state <= SEND;
        DONE: begin
          state <= IDLE;
          seq   <= seq + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .byte_done (byte_done),
    .tx        (tx)
  );

endmodule

// File: tb/tb_report_uart_tx.sv
// Scoreboard bench: stimulus queues expected bytes, a UART monitor decodes tx.
module tb_report_uart_tx;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_valid = 1'b0;
  logic [1:0] health_in = 2'b00;
  logic       data_ready;
  logic       tc;
  logic       busy;
  logic [7:0] seq_out;
  logic       tx;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         tc_count = 0;
  bit         chk_pkt_gap = 1'b0;
  logic [7:0] exp_q[$];

  report_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .data_valid           (data_valid),
    .health_in            (health_in),
    .data_ready           (data_ready),
    .transmission_complete(tc),
    .busy                 (busy),
    .seq_out              (seq_out),
    .tx                   (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2); exp_q.push_back(b3);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!data_ready && n < 1000) begin @(negedge clk); n++; end
    if (!data_ready) check(name, 0, 1);
  endtask

  task automatic wait_tc(input string name);
    int n = 0;
    while (!tc && n < 1000) begin @(negedge clk); n++; end
    if (!tc) check(name, 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_held(input int n, input logic [1:0] h);
    logic [7:0] s;
    health_in  = h;
    data_valid = 1'b1;
    for (int p = 0; p < n; p++) begin
      wait_ready("held_ready_timeout");
      s = 8'(p);
      push_bytes(8'hA5, s, {6'b0, h}, 8'hA5 + s + {6'b0, h});
      @(negedge clk);
      if (p == n - 1) data_valid = 1'b0;
      wait_tc("held_tc_timeout");
    end
  endtask

  // UART monitor: samples tx every cycle, decodes frames and pops the scoreboard.
  initial begin : monitor
    logic        prev;
    int          idle_run;
    int          frame_in_pkt;
    int          pkt_start;
    bit          have_prev;
    bit          shape_ok;
    bit          aborted;
    logic [39:0] s;
    logic [7:0]  b;
    logic [7:0]  e;
    prev = 1'b1; idle_run = 0; frame_in_pkt = 0; pkt_start = 0; have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1; idle_run = 0; frame_in_pkt = 0; have_prev = 1'b0;
        continue;
      end
      if (tc) begin
        check("tc_latency", cyc - pkt_start, 40 * C + 3);
        check("frames_per_pkt", frame_in_pkt, 4);
        tc_count++;
        frame_in_pkt = 0;
        have_prev = 1'b1;
      end
      if (prev && !tx) begin
        if (frame_in_pkt == 0) begin
          pkt_start = cyc;
          if (chk_pkt_gap && have_prev) check("pkt_gap", idle_run, 3);
        end else begin
          check("byte_gap", idle_run, 1);
        end
        s = '0;
        s[0] = tx;
        aborted = 1'b0;
        for (int k = 1; k < 40; k++) begin
          @(negedge clk);
          if (rst) begin aborted = 1'b1; break; end
          s[k] = tx;
        end
        if (aborted) begin
          prev = 1'b1; idle_run = 0; frame_in_pkt = 0; have_prev = 1'b0;
          continue;
        end
        shape_ok = 1'b1;
        for (int j = 0; j < 10; j++)
          for (int m = 1; m < 4; m++)
            if (s[4*j+m] !== s[4*j]) shape_ok = 1'b0;
        if (s[0] !== 1'b0 || s[36] !== 1'b1) shape_ok = 1'b0;
        for (int i = 0; i < 8; i++) b[i] = s[4*(i+1)];
        check("frame_shape", shape_ok, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", b, 32'h1ff);
        end else begin
          e = exp_q.pop_front();
          check("byte", b, e);
        end
        frame_in_pkt++;
        idle_run = 0;
        prev = 1'b1;
      end else begin
        if (tx) idle_run++;
        prev = tx;
      end
    end
  end

  initial begin : stimulus
    bit done;
    // 1: reset with data_valid asserted
    rst = 1'b1;
    data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_ready", data_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_seq", seq_out, 0);
      check("rst_tc", tc, 0);
    end
    data_valid = 1'b0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_tx", tx, 1);

    // 2: single packet, health 10
    push_bytes(8'hA5, 8'h00, 8'h02, 8'hA7);
    health_in = 2'b10;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    check("t2_busy", busy, 1);
    check("t2_ready", data_ready, 0);
    wait_tc("t2_tc_timeout");
    check("t2_tc_busy", busy, 1);
    @(negedge clk);
    check("t2_seq", seq_out, 1);
    check("t2_ready_after", data_ready, 1);

    // 3: extra requests and health changes during a packet are ignored
    push_bytes(8'hA5, 8'h01, 8'h01, 8'hA7);
    health_in = 2'b01;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge clk);
      data_valid = 1'b0;
      if (tc) done = 1'b1;
      else if (busy && (n % 13 == 0)) begin
        data_valid = 1'b1;
        health_in = n[1:0] ^ 2'b10;
      end
    end
    data_valid = 1'b0;
    if (!done) check("t3_tc_timeout", 0, 1);
    repeat (100) @(negedge clk);
    check("t3_idle", busy, 0);
    check("t3_seq", seq_out, 2);
    check("t3_queue_empty", exp_q.size(), 0);

    // 4: three packets with data_valid held, health 01 -> cks A6,A7,A8
    do_reset();
    chk_pkt_gap = 1'b1;
    run_held(3, 2'b01);
    @(negedge clk);
    check("t4_seq", seq_out, 3);

    // 5: 256 back-to-back packets, last carries seq FF, checksum A4
    do_reset();
    run_held(256, 2'b00);
    chk_pkt_gap = 1'b0;
    @(negedge clk);
    check("t5_seq_wrap", seq_out, 0);
    check("t5_ready", data_ready, 1);

    // 6: reset during B1 data bits, then a clean packet
    do_reset();
    exp_q.push_back(8'hA5);
    health_in = 2'b11;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_tx", tx, 1);
    check("t6_rst_tc", tc, 0);
    check("t6_rst_seq", seq_out, 0);
    check("t6_rst_busy", busy, 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("t6_no_tc", tc_count, 1 + 1 + 3 + 256);
    check("t6_queue_empty", exp_q.size(), 0);
    push_bytes(8'hA5, 8'h00, 8'h02, 8'hA7);
    health_in = 2'b10;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    wait_tc("t6_tc_timeout");
    repeat (20) @(negedge clk);
    check("t6_seq", seq_out, 1);

    check("final_queue_empty", exp_q.size(), 0);
    check("final_tc_count", tc_count, 262);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
